// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the multi-cycle control sequencer.
package cpu_ctrl_pkg;

    localparam int unsigned OPW_DEF     = 5;
    localparam int unsigned TMO_W_DEF   = 4;
    localparam int unsigned TMO_MAX_DEF = 15;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_REGREAD = 3'd3,
        ST_ALU     = 3'd4,
        ST_MEM     = 3'd5,
        ST_WB      = 3'd6,
        ST_HALT    = 3'd7
    } state_e;

    localparam logic [3:0] OP_STORE = 4'b0111;
    localparam logic [3:0] OP_LOAD  = 4'b1000;
    localparam logic [3:0] OP_BRC   = 4'b1100;
    localparam logic [3:0] OP_JMP   = 4'b1101;
    localparam logic [4:0] OP_HALT  = 5'b11111;

    typedef enum logic [2:0] {
        CL_ALU,
        CL_STORE,
        CL_LOAD,
        CL_BRC,
        CL_JMP,
        CL_HALT
    } op_class_e;

    // Registered stage strobes and status flags.
    typedef struct packed {
        logic fetch_en;
        logic dec_en;
        logic rf_en;
        logic alu_en;
        logic mem_en;
        logic mem_we;
        logic wb_en;
        logic busy;
        logic halted;
    } strobes_t;

    // Halt is checked on the full opcode before the 4-bit class field.
    function automatic op_class_e classify(input logic [4:0] op);
        op_class_e cls;
        cls = CL_ALU;
        if (op == OP_HALT) begin
            cls = CL_HALT;
        end else begin
            case (op[4:1])
                OP_STORE: cls = CL_STORE;
                OP_LOAD:  cls = CL_LOAD;
                OP_BRC:   cls = CL_BRC;
                OP_JMP:   cls = CL_JMP;
                default:  cls = CL_ALU;
            endcase
        end
        return cls;
    endfunction

endpackage

// File: rtl/cpu_ctrl_unit_mem_wait_timer.sv
// Memory wait-cycle counter; flags expiry when a wait is still pending at TMO_MAX.
module mem_wait_timer #(
    parameter int unsigned TMO_W   = 4,
    parameter int unsigned TMO_MAX = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expire_c
);

    logic [TMO_W-1:0] count_q;
    logic [TMO_W-1:0] count_d;

    always_comb begin
        expire_c = inc && (count_q == TMO_W'(TMO_MAX));
        count_d  = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && !expire_c) begin
            count_d = count_q + TMO_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/cpu_ctrl_unit.sv
// Multi-cycle instruction sequencer driving per-stage enables and PC control.
module cpu_ctrl_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned OPW     = OPW_DEF,
    parameter int unsigned TMO_W   = TMO_W_DEF,
    parameter int unsigned TMO_MAX = TMO_MAX_DEF
) (
    input  logic           I_clk,
    input  logic           I_rst,
    input  logic           I_run,
    input  logic           I_mem_ready,
    input  logic [OPW-1:0] I_opcode,
    input  logic           I_branch_taken,
    output logic           O_fetch_en,
    output logic           O_dec_en,
    output logic           O_rf_en,
    output logic           O_alu_en,
    output logic           O_mem_en,
    output logic           O_mem_we,
    output logic           O_wb_en,
    output logic           O_pc_inc,
    output logic           O_pc_load,
    output logic [2:0]     O_state,
    output logic           O_busy,
    output logic           O_halted,
    output logic           O_fault
);

    state_e    state_q, state_d;
    logic      fault_q, fault_d;
    strobes_t  out_q, out_d;
    op_class_e cls;
    logic      wait_inc;
    logic      tmo_expire_c;
    logic      pc_inc_c;
    logic      pc_load_c;

    assign cls      = classify(I_opcode[4:0]);
    assign wait_inc = ((state_q == ST_FETCH) || (state_q == ST_MEM)) && !I_mem_ready;

    // Any state change restarts the count, so each FETCH/MEM visit starts at zero.
    mem_wait_timer #(
        .TMO_W   (TMO_W),
        .TMO_MAX (TMO_MAX)
    ) u_timer (
        .clk      (I_clk),
        .rst      (I_rst),
        .clr      (state_d != state_q),
        .inc      (wait_inc),
        .expire_c (tmo_expire_c)
    );

    always_comb begin
        state_d   = state_q;
        fault_d   = fault_q;
        pc_inc_c  = 1'b0;
        pc_load_c = 1'b0;
        out_d     = '0;

        case (state_q)
            ST_IDLE: begin
                if (I_run && !fault_q) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (I_mem_ready) begin
                    state_d = ST_DECODE;
                end else if (tmo_expire_c) begin
                    state_d = ST_IDLE;
                    fault_d = 1'b1;
                end
            end
            ST_DECODE:  state_d = ST_REGREAD;
            ST_REGREAD: state_d = ST_ALU;
            ST_ALU: begin
                case (cls)
                    CL_HALT: state_d = ST_HALT;
                    CL_JMP: begin
                        pc_load_c = 1'b1;
                        state_d   = ST_FETCH;
                    end
                    CL_BRC: begin
                        pc_load_c = I_branch_taken;
                        pc_inc_c  = !I_branch_taken;
                        state_d   = ST_FETCH;
                    end
                    CL_LOAD, CL_STORE: state_d = ST_MEM;
                    default: state_d = ST_WB;
                endcase
            end
            ST_MEM: begin
                // The registered write strobe remembers store vs load for the whole access.
                if (I_mem_ready) begin
                    if (out_q.mem_we) begin
                        pc_inc_c = 1'b1;
                        state_d  = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (tmo_expire_c) begin
                    state_d = ST_IDLE;
                    fault_d = 1'b1;
                end
            end
            ST_WB: begin
                pc_inc_c = 1'b1;
                state_d  = I_run ? ST_FETCH : ST_IDLE;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase

        // Strobes are decoded from the next state so they align with O_state.
        out_d.fetch_en = (state_d == ST_FETCH);
        out_d.dec_en   = (state_d == ST_DECODE);
        out_d.rf_en    = (state_d == ST_REGREAD);
        out_d.alu_en   = (state_d == ST_ALU);
        out_d.mem_en   = (state_d == ST_MEM);
        out_d.mem_we   = (state_d == ST_MEM) &&
                         ((state_q == ST_MEM) ? out_q.mem_we : (cls == CL_STORE));
        out_d.wb_en    = (state_d == ST_WB);
        out_d.busy     = (state_d != ST_IDLE) && (state_d != ST_HALT);
        out_d.halted   = (state_d == ST_HALT);
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state_q <= ST_IDLE;
            fault_q <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            fault_q <= fault_d;
            out_q   <= out_d;
        end
    end

    assign O_fetch_en = out_q.fetch_en;
    assign O_dec_en   = out_q.dec_en;
    assign O_rf_en    = out_q.rf_en;
    assign O_alu_en   = out_q.alu_en;
    assign O_mem_en   = out_q.mem_en;
    assign O_mem_we   = out_q.mem_we;
    assign O_wb_en    = out_q.wb_en;
    assign O_busy     = out_q.busy;
    assign O_halted   = out_q.halted;
    assign O_fault    = fault_q;
    assign O_state    = state_q;
    // PC controls depend on same-cycle branch and ready inputs.
    assign O_pc_inc   = pc_inc_c;
    assign O_pc_load  = pc_load_c;

endmodule

// File: tb/tb_cpu_ctrl_unit.sv
// Scenario bench for cpu_ctrl_unit with a per-cycle expected-output scoreboard.
module tb_cpu_ctrl_unit;

    logic       clk = 1'b0;
    logic       I_rst;
    logic       I_run;
    logic       I_mem_ready;
    logic [4:0] I_opcode;
    logic       I_branch_taken;
    logic       O_fetch_en, O_dec_en, O_rf_en, O_alu_en, O_mem_en, O_mem_we, O_wb_en;
    logic       O_pc_inc, O_pc_load, O_busy, O_halted, O_fault;
    logic [2:0] O_state;

    int          errors = 0;
    int          checks = 0;
    int          stepn  = 0;
    string       tname  = "init";
    logic [14:0] exp_q[$];

    cpu_ctrl_unit dut (
        .I_clk          (clk),
        .I_rst          (I_rst),
        .I_run          (I_run),
        .I_mem_ready    (I_mem_ready),
        .I_opcode       (I_opcode),
        .I_branch_taken (I_branch_taken),
        .O_fetch_en     (O_fetch_en),
        .O_dec_en       (O_dec_en),
        .O_rf_en        (O_rf_en),
        .O_alu_en       (O_alu_en),
        .O_mem_en       (O_mem_en),
        .O_mem_we       (O_mem_we),
        .O_wb_en        (O_wb_en),
        .O_pc_inc       (O_pc_inc),
        .O_pc_load      (O_pc_load),
        .O_state        (O_state),
        .O_busy         (O_busy),
        .O_halted       (O_halted),
        .O_fault        (O_fault)
    );

    always #5 clk = ~clk;

    // Push the expected outputs for the current cycle, then pop and compare once settled.
    task automatic cyc(input int s, input bit inc, input bit ld, input bit we, input bit flt);
        logic [14:0] e;
        logic [14:0] got;
        e = {3'(s), (s == 1), (s == 2), (s == 3), (s == 4), (s == 5), we, (s == 6),
             inc, ld, (s >= 1 && s <= 6), (s == 7), flt};
        exp_q.push_back(e);
        #1;
        got = {O_state, O_fetch_en, O_dec_en, O_rf_en, O_alu_en, O_mem_en, O_mem_we,
               O_wb_en, O_pc_inc, O_pc_load, O_busy, O_halted, O_fault};
        e = exp_q.pop_front();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL %s step%0d: got st/fe/de/rf/al/me/we/wb/inc/ld/bsy/hlt/flt=%b required=%b",
                     tname, stepn, got, e);
        end
        stepn++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        I_rst = 1'b1;
        I_run = 1'b0;
        I_mem_ready = 1'b0;
        I_branch_taken = 1'b0;
        @(posedge clk);
        #1;
        I_rst = 1'b0;
        cyc(0, 0, 0, 0, 0);
    endtask

    // IDLE -> FETCH -> DECODE -> REGREAD with zero-wait fetch.
    task automatic front();
        I_run = 1'b1;
        I_mem_ready = 1'b1;
        cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(2, 0, 0, 0, 0);
        cyc(3, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        tname = "reset";
        do_reset();
        cyc(0, 0, 0, 0, 0);
    endtask

    task automatic test_back_to_back();
        tname = "alu_b2b";
        do_reset();
        I_opcode = 5'b00010;
        front();
        cyc(4, 0, 0, 0, 0);
        cyc(6, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(2, 0, 0, 0, 0);
        cyc(3, 0, 0, 0, 0);
        cyc(4, 0, 0, 0, 0);
        I_run = 1'b0;
        cyc(6, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
    endtask

    task automatic test_load();
        tname = "load";
        do_reset();
        I_opcode = 5'b10000;
        front();
        cyc(4, 0, 0, 0, 0);
        I_mem_ready = 1'b0;
        repeat (3) cyc(5, 0, 0, 0, 0);
        I_mem_ready = 1'b1;
        cyc(5, 0, 0, 0, 0);
        I_run = 1'b0;
        cyc(6, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
    endtask

    task automatic test_store();
        tname = "store";
        do_reset();
        I_opcode = 5'b01110;
        front();
        cyc(4, 0, 0, 0, 0);
        I_mem_ready = 1'b0;
        cyc(5, 0, 0, 1, 0);
        I_mem_ready = 1'b1;
        cyc(5, 1, 0, 1, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(2, 0, 0, 0, 0);
    endtask

    task automatic test_branch();
        tname = "brc_taken";
        do_reset();
        I_opcode = 5'b11000;
        front();
        I_branch_taken = 1'b1;
        cyc(4, 0, 1, 0, 0);
        cyc(1, 0, 0, 0, 0);
        tname = "brc_not_taken";
        do_reset();
        front();
        I_branch_taken = 1'b0;
        cyc(4, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        tname = "jump";
        do_reset();
        I_opcode = 5'b11010;
        front();
        I_branch_taken = 1'b0;
        cyc(4, 0, 1, 0, 0);
        cyc(1, 0, 0, 0, 0);
    endtask

    task automatic test_timeout();
        tname = "fetch_timeout";
        do_reset();
        I_opcode = 5'b00010;
        I_run = 1'b1;
        I_mem_ready = 1'b1;
        cyc(0, 0, 0, 0, 0);
        I_mem_ready = 1'b0;
        repeat (16) cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1);
        I_mem_ready = 1'b1;
        repeat (3) cyc(0, 0, 0, 0, 1);
        tname = "fault_clear";
        do_reset();
        tname = "ready_at_limit";
        I_run = 1'b1;
        I_mem_ready = 1'b1;
        cyc(0, 0, 0, 0, 0);
        I_mem_ready = 1'b0;
        repeat (15) cyc(1, 0, 0, 0, 0);
        I_mem_ready = 1'b1;
        cyc(1, 0, 0, 0, 0);
        cyc(2, 0, 0, 0, 0);
    endtask

    task automatic test_halt();
        tname = "halt";
        do_reset();
        I_opcode = 5'b11111;
        front();
        cyc(4, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            I_run = 1'(i % 2);
            cyc(7, 0, 0, 0, 0);
        end
    endtask

    task automatic test_reset_mid_mem();
        tname = "reset_mid_mem";
        do_reset();
        I_opcode = 5'b10000;
        front();
        cyc(4, 0, 0, 0, 0);
        I_mem_ready = 1'b0;
        cyc(5, 0, 0, 0, 0);
        I_rst = 1'b1;
        cyc(5, 0, 0, 0, 0);
        I_rst = 1'b0;
        I_run = 1'b0;
        cyc(0, 0, 0, 0, 0);
    endtask

    initial begin
        I_rst = 1'b1;
        I_run = 1'b0;
        I_mem_ready = 1'b0;
        I_opcode = 5'b00000;
        I_branch_taken = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_back_to_back();
        test_load();
        test_store();
        test_branch();
        test_timeout();
        test_halt();
        test_reset_mid_mem();
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard: got %0d leftover entries, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
